writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back logic of the 5-stage MIPS core. Latches MEM-stage

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/writeback_stage_load_extend.sv | 38 +++
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the write-back stage: word/register widths, load types, WB FSM states,
// and the MEM/WB pipeline register payload.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4
  } load_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic     valid;
    logic     regwen;
    regbits_t wsel;
    word_t    dat;
  } mem_wb_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load extender: picks a byte/halfword lane (big-endian) and sign/zero extends it.
// Compiled only when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module load_extend
  import cpu_types_pkg::*;
(
  input  load_t      i_ltype,
  input  logic [1:0] i_addr,
  input  word_t      i_dload,
  output word_t      o_dat
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_dat  = i_dload;
    // Byte lane 0 is the most significant byte
    case (i_addr)
      2'd0:    w_byte = i_dload[31:24];
      2'd1:    w_byte = i_dload[23:16];
      2'd2:    w_byte = i_dload[15:8];
      default: w_byte = i_dload[7:0];
    endcase
    w_half = i_addr[1] ? i_dload[15:0] : i_dload[31:16];
    case (i_ltype)
      LB:      o_dat = {{24{w_byte[7]}}, w_byte};
      LBU:     o_dat = {24'h000000, w_byte};
      LH:      o_dat = {{16{w_half[15]}}, w_half};
      LHU:     o_dat = {16'h0000, w_half};
      default: o_dat = i_dload;
    endcase
  end

endmodule
`endif

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write-back with load-wait stall and forwarding bus.
// Optional WB_LOAD_EXT_EN routes load data through load_extend (byte/halfword loads).
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             CLK,
  input  logic             nRst,
  input  logic             mem_valid,
  input  logic             mem_regwen,
  input  logic             mem_memtoreg,
  input  logic             mem_link,
  input  logic [4:0]       mem_wsel,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_pc4,
  input  logic [2:0]       mem_ltype,
  input  logic             dhit,
  input  logic [31:0]      dload,
  input  logic             flush,
  output logic             mem_stall,
  output logic             rf_wen,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic             fwd_valid,
  output logic [4:0]       fwd_sel,
  output logic [31:0]      fwd_dat,
  output logic [CNT_W-1:0] ld_wait_cnt
);

  localparam regbits_t LINK_SEL = REG_W'(LINK_REG);

  mem_wb_t          r_wb;
  mem_wb_t          w_wb_nxt;
  wb_state_t        r_state;
  wb_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  word_t            w_load_dat;

`ifdef WB_LOAD_EXT_EN
  load_extend u_load_extend (
    .i_ltype (load_t'(mem_ltype)),
    .i_addr  (mem_alu[1:0]),
    .i_dload (dload),
    .o_dat   (w_load_dat)
  );
`else
  logic w_unused_ltype;
  assign w_unused_ltype = ^mem_ltype;
  assign w_load_dat     = dload;
`endif

  assign mem_stall = mem_valid & mem_memtoreg & ~dhit;

  // Next WB register contents; flush and load stalls insert a bubble
  always_comb begin
    w_wb_nxt = r_wb;
    if (flush || mem_stall) begin
      w_wb_nxt.valid = 1'b0;
    end else begin
      w_wb_nxt.valid  = mem_valid;
      w_wb_nxt.regwen = mem_regwen | mem_link;
      w_wb_nxt.wsel   = mem_link ? LINK_SEL : mem_wsel;
      w_wb_nxt.dat    = mem_link ? mem_pc4 : (mem_memtoreg ? w_load_dat : mem_alu);
    end
  end

  always_ff @(posedge CLK or negedge nRst) begin
    if (!nRst) begin
      r_wb <= '0;
    end else begin
      r_wb <= w_wb_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Load-wait tracking and saturating stall counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (mem_stall) w_state_nxt = WAIT;
      WAIT: begin
        if (dhit || flush || !mem_valid) w_state_nxt = IDLE;
        else if (!mem_stall)             w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (mem_stall && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign rf_wen      = r_wb.valid & r_wb.regwen & (r_wb.wsel != '0);
  assign rf_wsel     = r_wb.wsel;
  assign rf_wdat     = r_wb.dat;
  assign fwd_valid   = rf_wen;
  assign fwd_sel     = r_wb.wsel;
  assign fwd_dat     = r_wb.dat;
  assign ld_wait_cnt = r_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand-written stall/reset
// sequences, and randomized traffic against a behavioural model.
module tb_writeback_stage;
  import cpu_types_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRst = 1'b0;
  logic             mem_valid, mem_regwen, mem_memtoreg, mem_link;
  logic [4:0]       mem_wsel;
  logic [31:0]      mem_alu, mem_pc4;
  logic [2:0]       mem_ltype;
  logic             dhit;
  logic [31:0]      dload;
  logic             flush;
  logic             mem_stall, rf_wen, fwd_valid;
  logic [4:0]       rf_wsel, fwd_sel;
  logic [31:0]      rf_wdat, fwd_dat;
  logic [CNT_W-1:0] ld_wait_cnt;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
    .CLK(CLK), .nRst(nRst), .mem_valid(mem_valid), .mem_regwen(mem_regwen),
    .mem_memtoreg(mem_memtoreg), .mem_link(mem_link), .mem_wsel(mem_wsel),
    .mem_alu(mem_alu), .mem_pc4(mem_pc4), .mem_ltype(mem_ltype), .dhit(dhit),
    .dload(dload), .flush(flush), .mem_stall(mem_stall), .rf_wen(rf_wen),
    .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .fwd_valid(fwd_valid), .fwd_sel(fwd_sel),
    .fwd_dat(fwd_dat), .ld_wait_cnt(ld_wait_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        v, rw, mtr, lk, dh, fl;
    logic [4:0]  wsel;
    logic [31:0] alu, pc4, dl;
    logic        e_stall, e_wen;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, rw, mtr, lk, input logic [4:0] ws,
                       input logic [31:0] alu, pc4, input logic [2:0] lt,
                       input logic dh, input logic [31:0] dl, input logic fl);
    mem_valid = v; mem_regwen = rw; mem_memtoreg = mtr; mem_link = lk; mem_wsel = ws;
    mem_alu = alu; mem_pc4 = pc4; mem_ltype = lt; dhit = dh; dload = dl; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle();
    nRst = 1'b0;
    repeat (2) @(negedge CLK);
    nRst = 1'b1;
  endtask

  // Expected load value from the architectural definition of each load type
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] lt,
                                      input logic [1:0] a);
`ifdef WB_LOAD_EXT_EN
    int ai;
    logic [7:0]  b;
    logic [15:0] h;
    ai = int'(a);
    b  = 8'((d >> ((3 - ai) * 8)) & 32'hFF);
    h  = a[1] ? d[15:0] : d[31:16];
    if (lt == 3'(LB))  return 32'($signed(b));
    if (lt == 3'(LBU)) return {24'h0, b};
    if (lt == 3'(LH))  return 32'($signed(h));
    if (lt == 3'(LHU)) return {16'h0, h};
    return d;
`else
    if (lt == 3'd7 && a == 2'd3) return d;
    return d;
`endif
  endfunction

  vec_t vecs[$];

  // Behavioural model state for random phase
  logic        m_valid, m_regwen;
  logic [4:0]  m_wsel;
  logic [31:0] m_dat;
  int          m_cnt;

  initial begin
    idle();
    vecs.push_back('{"alu",      1,1,0,0,0,0, 5'd5,  32'hDEADBEEF, 32'h0,   32'h0,        0,1,5'd5, 32'hDEADBEEF});
    vecs.push_back('{"link",     1,0,0,1,0,0, 5'd7,  32'h11111111, 32'h104, 32'h0,        0,1,5'd31,32'h104});
    vecs.push_back('{"zero_reg", 1,1,0,0,0,0, 5'd0,  32'h00000055, 32'h0,   32'h0,        0,0,5'd0, 32'h0});
    vecs.push_back('{"load_hit", 1,1,1,0,1,0, 5'd9,  32'h00000000, 32'h0,   32'h0BADF00D, 0,1,5'd9, 32'h0BADF00D});
    vecs.push_back('{"flush_hit",1,1,1,0,1,1, 5'd10, 32'h0,        32'h0,   32'hCAFEF00D, 0,0,5'd0, 32'h0});
    vecs.push_back('{"invalid",  0,1,0,0,0,0, 5'd3,  32'h33333333, 32'h0,   32'h0,        0,0,5'd0, 32'h0});
    vecs.push_back('{"stall",    1,1,1,0,0,0, 5'd4,  32'h0,        32'h0,   32'h44444444, 1,0,5'd0, 32'h0});
    vecs.push_back('{"no_regwen",1,0,0,0,0,0, 5'd12, 32'h12121212, 32'h0,   32'h0,        0,0,5'd0, 32'h0});

    do_reset();
    #1;
    chk("rst_rf_wen", 32'(rf_wen), 0);
    chk("rst_rf_wsel", 32'(rf_wsel), 0);
    chk("rst_rf_wdat", rf_wdat, 0);
    chk("rst_fwd_valid", 32'(fwd_valid), 0);
    chk("rst_cnt", 32'(ld_wait_cnt), 0);
    chk("rst_stall", 32'(mem_stall), 0);

    // Directed vector table
    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].v, vecs[i].rw, vecs[i].mtr, vecs[i].lk, vecs[i].wsel, vecs[i].alu,
            vecs[i].pc4, 3'(LW), vecs[i].dh, vecs[i].dl, vecs[i].fl);
      #1 chk({vecs[i].name, "_stall"}, 32'(mem_stall), 32'(vecs[i].e_stall));
      @(posedge CLK);
      #1;
      chk({vecs[i].name, "_wen"}, 32'(rf_wen), 32'(vecs[i].e_wen));
      chk({vecs[i].name, "_fwdv"}, 32'(fwd_valid), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        chk({vecs[i].name, "_wsel"}, 32'(rf_wsel), 32'(vecs[i].e_wsel));
        chk({vecs[i].name, "_wdat"}, rf_wdat, vecs[i].e_wdat);
        chk({vecs[i].name, "_fsel"}, 32'(fwd_sel), 32'(vecs[i].e_wsel));
        chk({vecs[i].name, "_fdat"}, fwd_dat, vecs[i].e_wdat);
      end
    end

    // Load miss: three waiting cycles then data return
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1, 1, 1, 0, 5'd6, 32'h0, 32'h0, 3'(LW), 0, 32'hFFFFFFFF, 0);
      #1 chk("miss_stall", 32'(mem_stall), 1);
      @(posedge CLK);
      #1 chk("miss_nowrite", 32'(rf_wen), 0);
    end
    chk("miss_cnt", 32'(ld_wait_cnt), 3);
    @(negedge CLK);
    drive(1, 1, 1, 0, 5'd6, 32'h0, 32'h0, 3'(LW), 1, 32'h12345678, 0);
    #1 chk("miss_ret_stall", 32'(mem_stall), 0);
    @(posedge CLK);
    #1;
    chk("miss_ret_wen", 32'(rf_wen), 1);
    chk("miss_ret_wsel", 32'(rf_wsel), 6);
    chk("miss_ret_wdat", rf_wdat, 32'h12345678);
    chk("miss_ret_cnt", 32'(ld_wait_cnt), 3);

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      drive(1, 1, 1, 0, 5'd6, 32'h0, 32'h0, 3'(LW), 0, 32'h0, 0);
    end
    @(posedge CLK);
    #1 chk("cnt_saturate", 32'(ld_wait_cnt), CMAX);

    // Reset while waiting on a load, after a committed write
    do_reset();
    @(negedge CLK);
    drive(1, 1, 0, 0, 5'd8, 32'hA5A5A5A5, 32'h0, 3'(LW), 0, 32'h0, 0);
    @(negedge CLK);
    drive(1, 1, 1, 0, 5'd8, 32'h0, 32'h0, 3'(LW), 0, 32'h0, 0);
    @(posedge CLK);
    #2 chk("pre_rst_cnt", 32'(ld_wait_cnt), 1);
    nRst = 1'b0;
    #1;
    chk("midrst_wen", 32'(rf_wen), 0);
    chk("midrst_wdat", rf_wdat, 0);
    chk("midrst_cnt", 32'(ld_wait_cnt), 0);
    idle();
    #1 chk("midrst_stall", 32'(mem_stall), 0);
    @(negedge CLK);
    nRst = 1'b1;
    @(posedge CLK);
    #1 chk("midrst_nowrite", 32'(rf_wen), 0);

`ifdef WB_LOAD_EXT_EN
    @(negedge CLK);
    drive(1, 1, 1, 0, 5'd2, 32'h0, 32'h0, 3'(LB), 1, 32'h80FF0000, 0);
    @(posedge CLK);
    #1 chk("ext_lb", rf_wdat, 32'hFFFFFF80);
    @(negedge CLK);
    drive(1, 1, 1, 0, 5'd2, 32'h0, 32'h0, 3'(LBU), 1, 32'h80FF0000, 0);
    @(posedge CLK);
    #1 chk("ext_lbu", rf_wdat, 32'h00000080);
`endif

    // Randomized traffic against the model
    do_reset();
    m_valid = 0; m_regwen = 0; m_wsel = 0; m_dat = 0; m_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      logic v, rw, mtr, lk, dh, fl, stall;
      logic [4:0]  ws;
      logic [31:0] alu, pc4, dl;
      logic [2:0]  lt;
      logic        e_wen;
      v   = ($urandom_range(0, 9) < 8);
      rw  = $urandom_range(0, 1) == 1;
      mtr = ($urandom_range(0, 2) == 0);
      lk  = ($urandom_range(0, 7) == 0);
      dh  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 9) == 0);
      ws  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      alu = $urandom; pc4 = $urandom; dl = $urandom;
      lt  = 3'($urandom_range(0, 7));
      @(negedge CLK);
      drive(v, rw, mtr, lk, ws, alu, pc4, lt, dh, dl, fl);
      stall = v && mtr && !dh;
      #1 chk("rnd_stall", 32'(mem_stall), 32'(stall));
      if (!fl && !stall) begin
        m_valid  = v;
        m_regwen = rw || lk;
        m_wsel   = lk ? 5'd31 : ws;
        m_dat    = lk ? pc4 : (mtr ? ext(dl, lt, alu[1:0]) : alu);
      end else begin
        m_valid = 0;
      end
      if (stall && m_cnt < int'(CMAX)) m_cnt++;
      @(posedge CLK);
      #1;
      e_wen = m_valid && m_regwen && (m_wsel != 5'd0);
      chk("rnd_wen", 32'(rf_wen), 32'(e_wen));
      chk("rnd_fwdv", 32'(fwd_valid), 32'(e_wen));
      chk("rnd_wsel", 32'(rf_wsel), 32'(m_wsel));
      chk("rnd_wdat", rf_wdat, m_dat);
      chk("rnd_fdat", fwd_dat, m_dat);
      chk("rnd_cnt", 32'(ld_wait_cnt), 32'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
